// File: rtl/order_stream_serializer.sv
// Order FIFO feeding a 3-beat 64-bit Avalon-ST packetizer with a per-packet sequence number.
// Define ORDER_SER_CHECKSUM_EN to fill the checksum word; otherwise it is sent as zero.
module order_stream_serializer #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        order_valid,
  output logic        order_ready,
  input  logic [63:0] order_symbol,
  input  logic [31:0] order_price,
  input  logic [31:0] order_qty,
  output logic [63:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_sop,
  output logic        st_eop,
  output logic [2:0]  st_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  logic [127:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [63:0]      beat1_q, beat1_d, beat2_q, beat2_d, data_q, data_d;
  logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic             full, empty, push, pop;
  logic [127:0]     head;
  logic [31:0]      chk;

  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    order_ready = !full && !reset;
    push        = order_valid && order_ready;
    // A pop happens when the beat registers are free now or become free at this edge.
    pop         = !empty && ((state_q == IDLE) || ((state_q == B2) && st_ready));
    head        = mem_q[rd_ptr_q];
`ifdef ORDER_SER_CHECKSUM_EN
    chk = head[127:96] ^ head[95:64] ^ head[63:32] ^ head[31:0] ^ seq_q;
`else
    chk = 32'h0;
`endif

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    state_d  = state_q;
    seq_d    = seq_q;
    beat1_d  = beat1_q;
    beat2_d  = beat2_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;

    case (state_q)
      IDLE: ;
      B0: if (st_ready) begin
        state_d = B1;
        data_d  = beat1_q;
        sop_d   = 1'b0;
      end
      B1: if (st_ready) begin
        state_d = B2;
        data_d  = beat2_q;
        eop_d   = 1'b1;
      end
      B2: if (st_ready) begin
        state_d = IDLE;
        data_d  = '0;
        valid_d = 1'b0;
        eop_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d = B0;
      valid_d = 1'b1;
      sop_d   = 1'b1;
      eop_d   = 1'b0;
      data_d  = head[127:64];
      beat1_d = head[63:0];
      beat2_d = {seq_q, chk};
      seq_d   = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {order_symbol, order_price, order_qty};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      seq_q    <= '0;
      beat1_q  <= '0;
      beat2_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      seq_q    <= seq_d;
      beat1_q  <= beat1_d;
      beat2_q  <= beat2_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign st_data  = data_q;
  assign st_valid = valid_q;
  assign st_sop   = sop_q;
  assign st_eop   = eop_q;
  assign st_empty = 3'b000;
endmodule

// File: tb/tb_order_stream_serializer.sv
// Randomized bench for order_stream_serializer: expected beats come from a packet-level queue model.
`timescale 1ns/1ps
module tb_order_stream_serializer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        order_valid = 1'b0;
  logic        order_ready;
  logic [63:0] order_symbol = '0;
  logic [31:0] order_price = '0;
  logic [31:0] order_qty = '0;
  logic [63:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;
  logic        st_sop;
  logic        st_eop;
  logic [2:0]  st_empty;

  always #5 clk = ~clk;

  order_stream_serializer #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
    .clk(clk), .reset(reset),
    .order_valid(order_valid), .order_ready(order_ready),
    .order_symbol(order_symbol), .order_price(order_price), .order_qty(order_qty),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } beat_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [31:0] model_seq = '0;
  int          checks = 0;
  int          failures = 0;
  int          viol = 0;
  int          cyc_cnt = 0;
  logic        in_pkt = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_sop = 1'b0;
  logic        prev_eop = 1'b0;

  always @(posedge clk) cyc_cnt++;

  // Collects accepted beats and counts stall-stability / mid-packet valid-drop violations.
  always @(negedge clk) begin
    if (reset) begin
      in_pkt = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!st_valid || st_data !== prev_data || st_sop !== prev_sop || st_eop !== prev_eop))
        viol++;
      if (in_pkt && !st_valid) viol++;
      if (st_valid && st_ready) begin
        got_q.push_back('{st_data, st_sop, st_eop, cyc_cnt});
        if (st_sop) in_pkt = 1'b1;
        if (st_eop) in_pkt = 1'b0;
      end
      prev_stall = st_valid && !st_ready;
      prev_data = st_data;
      prev_sop = st_sop;
      prev_eop = st_eop;
    end
  end

  // Packet-level model: orders leave in acceptance order, each numbered by a running count.
  function automatic void model_accept(input logic [63:0] s, input logic [31:0] p, input logic [31:0] q);
    logic [31:0] c;
`ifdef ORDER_SER_CHECKSUM_EN
    c = s[63:32] ^ s[31:0] ^ p ^ q ^ model_seq;
`else
    c = 32'h0;
`endif
    $display("order seq=%08h sym=%016h price=%0d qty=%0d", model_seq, s, p, q);
    exp_q.push_back('{s, 1'b1, 1'b0, 0});
    exp_q.push_back('{{p, q}, 1'b0, 1'b0, 0});
    exp_q.push_back('{{model_seq, c}, 1'b0, 1'b1, 0});
    model_seq = model_seq + 32'd1;
  endfunction

  task automatic push_order(input logic [63:0] s, input logic [31:0] p, input logic [31:0] q, output bit ok);
    int n = 0;
    ok = 1'b0;
    order_symbol = s;
    order_price = p;
    order_qty = q;
    order_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (order_ready) begin
        ok = 1'b1;
        model_accept(s, p, q);
      end
      @(posedge clk);
      #1;
      n++;
    end
    order_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    order_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    model_seq = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st_valid !== 1'b0 || st_sop !== 1'b0 || st_eop !== 1'b0 || st_data !== 64'h0 || st_empty !== 3'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b data=%h empty=%b expected all zero",
               st_valid, st_sop, st_eop, st_data, st_empty);
    end
    checks++;
    if (order_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_order_ready: got %b expected 0", order_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (order_ready !== 1'b1 || st_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0", order_ready, st_valid);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [31:0] c;
    do_reset();
    st_ready = 1'b1;
    push_order(64'h0000_0041_4150_4C00, 32'd15000, 32'd100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_accept: got no acceptance expected accept"); end
    @(negedge clk);
    checks++;
    if (st_valid !== 1'b0) begin failures++; $display("FAIL single_latency_t1: got valid=%b expected 0", st_valid); end
    @(negedge clk);
    checks++;
    if (st_valid !== 1'b1 || st_sop !== 1'b1 || st_data !== 64'h0000_0041_4150_4C00) begin
      failures++;
      $display("FAIL single_latency_t2: got valid=%b sop=%b data=%h expected 1 1 0000004141504c00", st_valid, st_sop, st_data);
    end
    wait_drain();
`ifdef ORDER_SER_CHECKSUM_EN
    c = 32'h0000_0041 ^ 32'h4150_4C00 ^ 32'd15000 ^ 32'd100;
`else
    c = 32'h0;
`endif
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL single_count: got %0d beats expected 3", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== 64'h0000_0041_4150_4C00 || got_q[0].sop !== 1'b1 || got_q[0].eop !== 1'b0) begin
        failures++; $display("FAIL single_beat0: got %h/%b/%b expected 0000004141504c00/1/0", got_q[0].data, got_q[0].sop, got_q[0].eop);
      end
      checks++;
      if (got_q[1].data !== 64'h0000_3A98_0000_0064 || got_q[1].sop !== 1'b0 || got_q[1].eop !== 1'b0) begin
        failures++; $display("FAIL single_beat1: got %h/%b/%b expected 00003a9800000064/0/0", got_q[1].data, got_q[1].sop, got_q[1].eop);
      end
      checks++;
      if (got_q[2].data !== {32'h0, c} || got_q[2].sop !== 1'b0 || got_q[2].eop !== 1'b1) begin
        failures++; $display("FAIL single_beat2: got %h/%b/%b expected %h/0/1", got_q[2].data, got_q[2].sop, got_q[2].eop, {32'h0, c});
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    st_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_order({$urandom, $urandom}, $urandom, $urandom, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_accept%0d: got no acceptance expected accept", i); end
    end
    wait_drain();
    checks++;
    if (got_q.size() != 12) begin
      failures++;
      $display("FAIL b2b_count: got %0d beats expected 12", got_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_q[i].data !== exp_q[i].data || got_q[i].sop !== exp_q[i].sop || got_q[i].eop !== exp_q[i].eop || got_q[i].cyc != got_q[0].cyc + i) begin
          failures++;
          $display("FAIL b2b_beat%0d: got %h/%b/%b cyc=%0d expected %h/%b/%b cyc=%0d", i, got_q[i].data, got_q[i].sop,
                   got_q[i].eop, got_q[i].cyc, exp_q[i].data, exp_q[i].sop, exp_q[i].eop, got_q[0].cyc + i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[3*i+2].data[63:32] !== 32'(i)) begin
          failures++; $display("FAIL b2b_seq%0d: got %h expected %h", i, got_q[3*i+2].data[63:32], 32'(i));
        end
      end
    end
  endtask

  task automatic test_backpressure_full();
    int accepted = 0;
    int n = 0;
    bit done = 1'b0;
    logic [63:0] first_sym;
    do_reset();
    st_ready = 1'b0;
    first_sym = '0;
    while (!done && n < 20) begin
      order_symbol = {$urandom, $urandom};
      order_price = $urandom;
      order_qty = $urandom;
      order_valid = 1'b1;
      if (n == 0) first_sym = order_symbol;
      @(negedge clk);
      if (order_ready) begin
        accepted++;
        model_accept(order_symbol, order_price, order_qty);
      end else begin
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    order_valid = 1'b0;
    checks++;
    if (accepted != DEPTH + 1) begin
      failures++; $display("FAIL full_accept_count: got %0d expected %0d", accepted, DEPTH + 1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (st_valid !== 1'b1 || st_sop !== 1'b1 || st_data !== first_sym || order_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold_beat0: got valid=%b sop=%b data=%h ready=%b expected 1 1 %h 0", st_valid, st_sop, st_data, order_ready, first_sym);
    end
    @(posedge clk);
    #1;
    st_ready = 1'b1;
    wait_drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL full_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].sop !== exp_q[i].sop || got_q[i].eop !== exp_q[i].eop) begin
        failures++;
        $display("FAIL full_beat%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].data, got_q[i].sop, got_q[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_random_ready();
    int gen = 0;
    int acc_n = 0;
    int n = 0;
    int viol_start;
    bit acc;
    do_reset();
    viol_start = viol;
    while (acc_n < 100 && n < 5000) begin
      @(negedge clk);
      acc = order_valid && order_ready;
      if (acc) begin
        model_accept(order_symbol, order_price, order_qty);
        acc_n++;
      end
      @(posedge clk);
      #1;
      n++;
      st_ready = 1'($urandom_range(0, 1));
      if (acc || !order_valid) begin
        if (gen < 100 && $urandom_range(0, 3) != 0) begin
          order_symbol = {$urandom, $urandom};
          order_price = $urandom;
          order_qty = $urandom;
          order_valid = 1'b1;
          gen++;
        end else begin
          order_valid = 1'b0;
        end
      end
    end
    order_valid = 1'b0;
    st_ready = 1'b1;
    checks++;
    if (acc_n != 100) begin failures++; $display("FAIL rand_accepted: got %0d expected 100", acc_n); end
    wait_drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].sop !== exp_q[i].sop || got_q[i].eop !== exp_q[i].eop) begin
        failures++;
        $display("FAIL rand_beat%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].data, got_q[i].sop, got_q[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
      end
    end
    checks++;
    if (viol != viol_start) begin
      failures++; $display("FAIL rand_stall_stability: got %0d violations expected 0", viol - viol_start);
    end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE;
    want[1] = 32'hFFFF_FFFF;
    want[2] = 32'h0000_0000;
    do_reset();
    @(negedge clk);
    dut.seq_q = 32'hFFFF_FFFE;
    model_seq = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    st_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_order({$urandom, $urandom}, $urandom, $urandom, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL wrap_accept%0d: got no acceptance expected accept", i); end
    end
    wait_drain();
    checks++;
    if (got_q.size() != 9) begin
      failures++;
      $display("FAIL wrap_count: got %0d beats expected 9", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[3*i+2].data !== exp_q[3*i+2].data || got_q[3*i+2].data[63:32] !== want[i]) begin
          failures++;
          $display("FAIL wrap_seq%0d: got %h expected %h (seq %h)", i, got_q[3*i+2].data, exp_q[3*i+2].data, want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int n = 0;
    do_reset();
    st_ready = 1'b0;
    push_order({$urandom, $urandom}, $urandom, $urandom, ok);
    while (!st_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    st_ready = 1'b1;
    @(posedge clk);
    #1;
    st_ready = 1'b0;
    checks++;
    if (!ok || st_valid !== 1'b1 || st_sop !== 1'b0 || st_eop !== 1'b0) begin
      failures++;
      $display("FAIL midrst_in_b1: got ok=%b valid=%b sop=%b eop=%b expected 1 1 0 0", ok, st_valid, st_sop, st_eop);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (st_valid !== 1'b0 || order_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_after: got valid=%b ready=%b expected 0 1", st_valid, order_ready);
    end
    got_q.delete();
    exp_q.delete();
    model_seq = '0;
    @(posedge clk);
    #1;
    st_ready = 1'b1;
    push_order({$urandom, $urandom}, $urandom, $urandom, ok);
    wait_drain();
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL midrst_count: got %0d beats expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i].data !== exp_q[i].data || got_q[i].sop !== exp_q[i].sop || got_q[i].eop !== exp_q[i].eop) begin
          failures++;
          $display("FAIL midrst_beat%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].data, got_q[i].sop, got_q[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
        end
      end
      checks++;
      if (got_q[2].data[63:32] !== 32'h0) begin
        failures++; $display("FAIL midrst_seq: got %h expected 00000000", got_q[2].data[63:32]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure_full();
    test_random_ready();
    test_seq_wrap();
    test_reset_mid_packet();
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL stream_protocol: got %0d stall/drop violations expected 0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
